// File: rtl/fm_demod_pkg.sv
// Shared constants and helpers for the FM discriminator: output field offsets,
// channel-index width helper and the signed saturation function.
package fm_demod_pkg;

    localparam int ANGLE_LSB    = 16;
    localparam int CH_LSB       = 16;
    localparam int FREQ_LSB     = 0;
    localparam int FREQ_FIELD_W = 16;
    localparam int CH_FIELD_W   = 8;

    // A single channel still needs a 1-bit index so the history arrays stay addressable.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fm_deemph.sv
// Per-channel single-pole de-emphasis IIR: y += (x - y) >>> DEEMPH_SHIFT.
// Only instantiated when FM_DEEMPH_EN is defined; the update is combinational.
module fm_deemph
    import fm_demod_pkg::*;
#(
    parameter int NUM_CH       = 1,
    parameter int CH_W         = 1,
    parameter int OUT_W        = 16,
    parameter int DEEMPH_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [CH_W-1:0]         ch,
    input  logic                    prime,
    input  logic signed [OUT_W-1:0] x,
    output logic signed [OUT_W-1:0] y
);

    localparam int EXT_W = OUT_W + 1;

    logic signed [OUT_W-1:0] y_mem [NUM_CH];
    logic signed [EXT_W-1:0] y_cur;
    logic signed [EXT_W-1:0] step;
    logic signed [EXT_W-1:0] sum;

    // One extra bit keeps x - y exact before the coefficient shift.
    always_comb begin
        y_cur = EXT_W'(y_mem[ch]);
        step  = (EXT_W'(x) - y_cur) >>> DEEMPH_SHIFT;
        sum   = y_cur + step;
        y     = prime ? '0 : OUT_W'(sat(32'(sum), OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) y_mem[i] <= '0;
        end else if (we) begin
            y_mem[ch] <= y;
        end
    end

endmodule

// File: rtl/fm_discriminator.sv
// Phase-difference FM discriminator for interleaved AXI-Stream angle samples.
// Define FM_DEEMPH_EN to add the per-channel de-emphasis filter (fm_deemph).
module fm_discriminator
    import fm_demod_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int ANGLE_W                = 16,
    parameter int OUT_W                  = 16,
    parameter int NUM_CH                 = 1,
    parameter int GAIN_SHIFT             = 1,
    parameter int DEEMPH_SHIFT           = 4
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic                                s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                sync_err
);

    localparam int CH_W    = ch_width(NUM_CH);
    localparam int MSTRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

    logic [ANGLE_W-1:0]               prev_angle [NUM_CH];
    logic [NUM_CH-1:0]                primed;
    logic [CH_W-1:0]                  ch;
    logic                             accept;
    logic                             last_ch;
    logic [ANGLE_W-1:0]               angle;
    logic signed [ANGLE_W-1:0]        diff;
    logic signed [ANGLE_W-1:0]        diff_sh;
    logic signed [OUT_W-1:0]          freq_sat;
    logic signed [OUT_W-1:0]          freq_out;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] out_word;
    logic                             unused_mag;

    assign unused_mag      = ^s00_axis_tdata[ANGLE_LSB-1:0];
    assign s00_axis_tready = m00_axis_tready || !m00_axis_tvalid;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign last_ch         = (ch == CH_W'(NUM_CH - 1));
    assign angle           = s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1 -: ANGLE_W];

    // Modulo-2^ANGLE_W subtraction read as signed gives the shortest-path phase step.
    always_comb begin
        diff     = angle - prev_angle[ch];
        diff_sh  = diff >>> GAIN_SHIFT;
        freq_sat = OUT_W'(sat(32'(diff_sh), OUT_W));
    end

`ifdef FM_DEEMPH_EN
    fm_deemph #(
        .NUM_CH       (NUM_CH),
        .CH_W         (CH_W),
        .OUT_W        (OUT_W),
        .DEEMPH_SHIFT (DEEMPH_SHIFT)
    ) u_deemph (
        .clk   (s00_axis_aclk),
        .rst_n (s00_axis_aresetn),
        .we    (accept),
        .ch    (ch),
        .prime (!primed[ch]),
        .x     (freq_sat),
        .y     (freq_out)
    );
`else
    localparam int UNUSED_DEEMPH_SHIFT = DEEMPH_SHIFT;
    assign freq_out = primed[ch] ? freq_sat : '0;
`endif

    always_comb begin
        out_word                            = '0;
        out_word[FREQ_LSB +: FREQ_FIELD_W]  = FREQ_FIELD_W'(freq_out);
        out_word[CH_LSB +: CH_FIELD_W]      = CH_FIELD_W'(ch);
    end

    // NOTE: the history is a register array that must clear on reset so every channel re-primes;
    // a loop in the reset branch is fine here because it is flops, not a RAM macro.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) prev_angle[i] <= '0;
            primed <= '0;
            ch     <= '0;
        end else if (accept) begin
            // NOTE: state updates use non-blocking assignments so every read above sees pre-edge values.
            prev_angle[ch] <= angle;
            primed[ch]     <= 1'b1;
            ch             <= (s00_axis_tlast || last_ch) ? '0 : ch + CH_W'(1);
        end
    end

    // Single output register; a new accept can reload it in the same cycle it is consumed.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            sync_err        <= 1'b0;
        end else begin
            sync_err <= accept && s00_axis_tlast && !last_ch;
            if (accept) begin
                m00_axis_tvalid <= 1'b1;
                m00_axis_tlast  <= s00_axis_tlast;
                m00_axis_tdata  <= out_word;
                m00_axis_tstrb  <= MSTRB_W'(s00_axis_tstrb);
            end else if (m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
